program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: text-memory address width.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 4: opcode field width.
REQ-003 SHALL have parameter DATA_WIDTH, default ADDR_WIDTH + INSTRUCTION_WIDTH: program word width.
REQ-004 SHALL have parameter CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200).
REQ-005 SHALL have parameter TIMEOUT_BITS, default 20: max idle bit-times between the two bytes of one word.
REQ-006 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-007 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-008 SHALL have port rx  input  1  UART serial line, 8N1, idle high, asynchronous to clk.
REQ-009 SHALL have port program_write  output  1  one-cycle write strobe to text memory.
REQ-010 SHALL have port program_cmd  output  DATA_WIDTH  word to write, {opcode, address}.
REQ-011 SHALL have port uart_address  output  ADDR_WIDTH  text-memory write address.
REQ-012 SHALL have port loading  output  1  high while a program load is in progress; holds CPU in reset.
REQ-013 SHALL have port done  output  1  one-cycle pulse on end-of-program marker.
REQ-014 SHALL have port frame_error  output  1  sticky; set on bad stop bit or inter-byte timeout.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-016 Receiver FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START on synced rx low.
REQ-017 START SHALL re-sample at CLKS_PER_BIT/2; rx high there -> back to IDLE (glitch), no byte, no error.
REQ-018 DATA SHALL sample 8 bits LSB-first, each CLKS_PER_BIT after the previous sample point.
REQ-019 STOP SHALL sample once; high -> byte_valid pulse one cycle; low -> frame_error set, byte discarded, then wait in IDLE for rx high.
REQ-020 Assembler FSM SHALL have states EXPECT_LO, EXPECT_HI; byte in EXPECT_LO latched as address field, -> EXPECT_HI.
REQ-021 Byte in EXPECT_HI with [7:4]==0: program_cmd <= {byte[3:0], lo_byte}, program_write pulses the cycle after byte_valid, uart_address increments by 1 the cycle after the strobe, -> EXPECT_LO.
REQ-022 Byte in EXPECT_HI with [7:4]==4'hF: end marker; no write, done pulses one cycle, loading falls same cycle, uart_address -> 0, -> EXPECT_LO.
REQ-023 Byte in EXPECT_HI with [7:4] any other value: frame_error set, no write, -> EXPECT_LO.
REQ-024 loading SHALL rise the cycle after the first byte_valid while loading==0 and stay high until done.
REQ-025 uart_address SHALL wrap from 2^ADDR_WIDTH-1 to 0 silently.
REQ-026 In EXPECT_HI, TIMEOUT_BITS*CLKS_PER_BIT cycles with the receiver in IDLE SHALL set frame_error and return to EXPECT_LO; loading and uart_address unchanged.
REQ-027 Any receiver framing error while in EXPECT_HI SHALL also return the assembler to EXPECT_LO.
REQ-028 frame_error SHALL clear only on the next accepted word write or on reset.
REQ-029 program_cmd SHALL hold its last value between strobes.
REQ-030 Bit counter and baud counter widths SHALL be $clog2 of their ranges; no overflow at CLKS_PER_BIT max.

Reset
REQ-031 On reset low, immediately: receiver IDLE, assembler EXPECT_LO, synchronizer 1, program_write 0, program_cmd 0, uart_address 0, loading 0, done 0, frame_error 0.
REQ-032 Reset mid-byte or mid-word SHALL discard all partial data; first frame after release is treated as a low byte.

Structure
REQ-033 Receiver and assembler state enums, END_NIBBLE (4'hF) and default CLKS_PER_BIT SHALL live in a shared package next to the instructions package.
REQ-034 Bit-level receiver SHALL be one sub-module UartRx (rx in; byte, byte_valid, stop_error out); word assembly stays in program_loader.

Verification (CLKS_PER_BIT=4, TIMEOUT_BITS=20)
REQ-035 Send 0x2A, 0x05 -> one program_write with program_cmd=12'h52A at uart_address=0, then uart_address=1, loading=1.
REQ-036 Send words 0x01/0x01, 0x02/0x03, then 0x00/0xF0 -> writes 12'h101@0, 12'h302@1, done pulse, loading=0, uart_address=0.
REQ-037 Send 0x2A with stop bit low -> frame_error=1, no write; then 0x10/0x07 -> write 12'h710@0, frame_error=0.
REQ-038 Send 0x33, idle 80+ cycles -> frame_error=1, then 0x44/0x02 -> write 12'h244 (0x44 treated as low byte).
REQ-039 256 valid words -> uart_address wraps to 0, word 257 written at 0.
REQ-040 Assert reset during DATA bits of high byte -> all outputs reset values; next 0x11/0x01 -> write 12'h111@0; 1-cycle rx low pulse -> no byte.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared receiver/assembler state types and constants for the UART program loader.
package program_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef enum logic {
    EXPECT_LO,
    EXPECT_HI
  } asm_state_t;

  localparam logic [3:0] END_NIBBLE   = 4'hF;
  localparam logic [3:0] WRITE_NIBBLE = 4'h0;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_TIMEOUT_BITS = 20;

  // Width of a counter running over 0..range_max-1, never narrower than one bit.
  function automatic int counter_width(input int range_max);
    return (range_max > 1) ? $clog2(range_max) : 1;
  endfunction

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver: synchronizes rx, frames one byte and flags bad stop bits.
module UartRx
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stop_error,
  output logic       rx_idle
);

  localparam int BAUD_W = counter_width(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
  // Detection already costs a cycle, so the start re-sample lands half a bit after the falling edge.
  localparam logic [BAUD_W-1:0] HALF_BIT =
    BAUD_W'((CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0);

  logic              rx_meta;
  logic              rx_sync;
  rx_state_t         state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_cnt, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic [7:0]        byte_next;
  logic              wait_high, wait_high_next;
  logic              valid_next;
  logic              stop_err_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      rx_byte    <= '0;
      wait_high  <= 1'b0;
      byte_valid <= 1'b0;
      stop_error <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      rx_byte    <= byte_next;
      wait_high  <= wait_high_next;
      byte_valid <= valid_next;
      stop_error <= stop_err_next;
    end
  end

  always_comb begin
    state_next     = state;
    baud_next      = baud_cnt;
    bit_next       = bit_cnt;
    shift_next     = shift_reg;
    byte_next      = rx_byte;
    wait_high_next = wait_high;
    valid_next     = 1'b0;
    stop_err_next  = 1'b0;

    case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        // After a framing error the line must return high before a new start bit counts.
        if (wait_high) begin
          if (rx_sync) wait_high_next = 1'b0;
        end else if (!rx_sync) begin
          state_next = START;
        end
      end

      START: begin
        if (baud_cnt == HALF_BIT) begin
          baud_next  = '0;
          state_next = rx_sync ? IDLE : DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (baud_cnt == BIT_END) begin
          baud_next  = '0;
          shift_next = {rx_sync, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        if (baud_cnt == BIT_END) begin
          baud_next  = '0;
          state_next = IDLE;
          if (rx_sync) begin
            valid_next = 1'b1;
            byte_next  = shift_reg;
          end else begin
            stop_err_next  = 1'b1;
            wait_high_next = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign rx_idle = (state == IDLE);

endmodule

// File: rtl/program_loader.sv
// Loads a program over UART: pairs received bytes into {opcode, address} words
// and streams them into text memory while holding the CPU in reset.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH        = 8,
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
  parameter int CLKS_PER_BIT      = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS      = DEFAULT_TIMEOUT_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  program_write,
  output logic [DATA_WIDTH-1:0] program_cmd,
  output logic [ADDR_WIDTH-1:0] uart_address,
  output logic                  loading,
  output logic                  done,
  output logic                  frame_error
);

  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W          = counter_width(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       stop_error;
  logic       rx_idle;

  UartRx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .stop_error(stop_error),
    .rx_idle   (rx_idle)
  );

  asm_state_t                   asm_state, asm_next;
  logic [7:0]                   lo_byte, lo_next;
  logic [TMO_W-1:0]             idle_cnt, idle_next;
  logic                         write_next;
  logic [DATA_WIDTH-1:0]        cmd_next;
  logic [ADDR_WIDTH-1:0]        addr_next;
  logic                         loading_next;
  logic                         done_next;
  logic                         ferr_next;
  logic [INSTRUCTION_WIDTH-1:0] opcode;
  logic [ADDR_WIDTH-1:0]        addr_field;

  assign opcode     = INSTRUCTION_WIDTH'(rx_byte[3:0]);
  assign addr_field = ADDR_WIDTH'(lo_byte);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_state     <= EXPECT_LO;
      lo_byte       <= '0;
      idle_cnt      <= '0;
      program_write <= 1'b0;
      program_cmd   <= '0;
      uart_address  <= '0;
      loading       <= 1'b0;
      done          <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      asm_state     <= asm_next;
      lo_byte       <= lo_next;
      idle_cnt      <= idle_next;
      program_write <= write_next;
      program_cmd   <= cmd_next;
      uart_address  <= addr_next;
      loading       <= loading_next;
      done          <= done_next;
      frame_error   <= ferr_next;
    end
  end

  always_comb begin
    asm_next     = asm_state;
    lo_next      = lo_byte;
    idle_next    = '0;
    write_next   = 1'b0;
    cmd_next     = program_cmd;
    addr_next    = uart_address;
    loading_next = loading;
    done_next    = 1'b0;
    ferr_next    = frame_error;

    // The address advances only once the memory has seen the strobe at the old address.
    if (program_write) addr_next = uart_address + 1'b1;

    if (stop_error) begin
      ferr_next = 1'b1;
      asm_next  = EXPECT_LO;
    end

    case (asm_state)
      EXPECT_LO: begin
        if (byte_valid) begin
          lo_next      = rx_byte;
          asm_next     = EXPECT_HI;
          loading_next = 1'b1;
        end
      end

      EXPECT_HI: begin
        if (byte_valid) begin
          asm_next = EXPECT_LO;
          if (rx_byte[7:4] == WRITE_NIBBLE) begin
            write_next = 1'b1;
            cmd_next   = DATA_WIDTH'({opcode, addr_field});
            ferr_next  = 1'b0;
          end else if (rx_byte[7:4] == END_NIBBLE) begin
            done_next    = 1'b1;
            loading_next = 1'b0;
            addr_next    = '0;
          end else begin
            ferr_next = 1'b1;
          end
        end else if (rx_idle && !stop_error) begin
          // A half-received word is abandoned if the line stays quiet too long.
          if (idle_cnt == TMO_LAST) begin
            ferr_next = 1'b1;
            asm_next  = EXPECT_LO;
          end else begin
            idle_next = idle_cnt + 1'b1;
          end
        end
      end

      default: asm_next = EXPECT_LO;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table, hand sequences and random words vs a word-level model.
module tb_program_loader;

  localparam int CPB = 4;
  localparam int TMO = 20;
  localparam int AW  = 8;
  localparam int IW  = 4;
  localparam int DW  = AW + IW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic          program_write;
  logic [DW-1:0] program_cmd;
  logic [AW-1:0] uart_address;
  logic          loading;
  logic          done;
  logic          frame_error;

  program_loader #(
    .ADDR_WIDTH(AW),
    .INSTRUCTION_WIDTH(IW),
    .DATA_WIDTH(DW),
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .program_write(program_write),
    .program_cmd  (program_cmd),
    .uart_address (uart_address),
    .loading      (loading),
    .done         (done),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] cmd;
    logic [AW-1:0] addr;
  } wr_t;

  typedef struct {
    logic [7:0]    lo;
    logic [7:0]    hi;
    logic          write;
    logic [DW-1:0] cmd;
    logic [AW-1:0] addr;
    logic          done;
    logic          loading;
    logic          ferr;
    logic [AW-1:0] next_addr;
  } vec_t;

  wr_t  seen_q[$];
  wr_t  exp_q[$];
  int   seen_done = 0;
  int   rd_idx = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [AW-1:0] m_addr;
  logic          m_loading;
  logic          m_ferr;
  logic          m_have_lo;
  logic [7:0]    m_lo;
  int            m_done = 0;

  vec_t vecs[9];

  // Observed memory writes and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (program_write) seen_q.push_back('{program_cmd, uart_address});
      if (done) seen_done++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic driveBit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_ok);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    driveBit(stop_ok);
    rx = 1'b1;
  endtask

  // Word-level reference: each accepted byte either opens a word or closes it.
  task automatic modelByte(input logic [7:0] b);
    if (!m_have_lo) begin
      m_lo      = b;
      m_have_lo = 1'b1;
      m_loading = 1'b1;
    end else begin
      m_have_lo = 1'b0;
      if (b[7:4] == 4'h0) begin
        exp_q.push_back('{{b[3:0], m_lo}, m_addr});
        m_addr = m_addr + 1'b1;
        m_ferr = 1'b0;
      end else if (b[7:4] == 4'hF) begin
        m_done++;
        m_loading = 1'b0;
        m_addr    = '0;
      end else begin
        m_ferr = 1'b1;
      end
    end
  endtask

  task automatic modelFrameLoss();
    m_ferr    = 1'b1;
    m_have_lo = 1'b0;
  endtask

  task automatic modelReset();
    m_addr    = '0;
    m_loading = 1'b0;
    m_ferr    = 1'b0;
    m_have_lo = 1'b0;
    exp_q.delete();
    rd_idx = seen_q.size();
  endtask

  task automatic checkModel(input string tag);
    int n;
    wr_t e;
    n = seen_q.size() - rd_idx;
    checkOutput({tag, "_writes"}, n, exp_q.size());
    while (exp_q.size() > 0 && rd_idx < seen_q.size()) begin
      e = exp_q.pop_front();
      checkOutput({tag, "_cmd"}, seen_q[rd_idx].cmd, e.cmd);
      checkOutput({tag, "_addr"}, seen_q[rd_idx].addr, e.addr);
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = seen_q.size();
    checkOutput({tag, "_done"}, seen_done, m_done);
    checkOutput({tag, "_loading"}, loading, m_loading);
    checkOutput({tag, "_frame_error"}, frame_error, m_ferr);
    checkOutput({tag, "_uart_address"}, uart_address, m_addr);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_program_write"}, program_write, 0);
    checkOutput({tag, "_program_cmd"}, program_cmd, 0);
    checkOutput({tag, "_uart_address"}, uart_address, 0);
    checkOutput({tag, "_loading"}, loading, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_frame_error"}, frame_error, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_idx;
    int base_done;
    int gap;
    logic [7:0] lo;
    logic [7:0] hi;

    vecs[0] = '{8'h2A, 8'h05, 1'b1, 12'h52A, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01};
    vecs[1] = '{8'h00, 8'hF0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{8'h01, 8'h01, 1'b1, 12'h101, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01};
    vecs[3] = '{8'h02, 8'h03, 1'b1, 12'h302, 8'h01, 1'b0, 1'b1, 1'b0, 8'h02};
    vecs[4] = '{8'h00, 8'hF0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{8'h12, 8'h37, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[6] = '{8'h34, 8'h0C, 1'b1, 12'hC34, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01};
    vecs[7] = '{8'hFF, 8'h0F, 1'b1, 12'hFFF, 8'h01, 1'b0, 1'b1, 1'b0, 8'h02};
    vecs[8] = '{8'hAB, 8'hF5, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

    reset = 1'b0;
    rx    = 1'b1;
    idleCycles(3);
    checkResetValues("por");
    reset = 1'b1;
    idleCycles(10);
    modelReset();

    for (int r = 0; r < 9; r++) begin
      base_idx  = seen_q.size();
      base_done = seen_done;
      applyStimulus(vecs[r].lo, 1'b1);
      applyStimulus(vecs[r].hi, 1'b1);
      idleCycles(8);
      modelByte(vecs[r].lo);
      modelByte(vecs[r].hi);
      checkOutput($sformatf("vec%0d_write", r), seen_q.size() - base_idx, 32'(vecs[r].write));
      if (vecs[r].write && seen_q.size() > base_idx) begin
        checkOutput($sformatf("vec%0d_cmd", r), seen_q[base_idx].cmd, vecs[r].cmd);
        checkOutput($sformatf("vec%0d_addr", r), seen_q[base_idx].addr, vecs[r].addr);
      end
      checkOutput($sformatf("vec%0d_done", r), seen_done - base_done, 32'(vecs[r].done));
      checkOutput($sformatf("vec%0d_loading", r), loading, vecs[r].loading);
      checkOutput($sformatf("vec%0d_frame_error", r), frame_error, vecs[r].ferr);
      checkOutput($sformatf("vec%0d_uart_address", r), uart_address, vecs[r].next_addr);
      exp_q.delete();
      rd_idx = seen_q.size();
    end

    // Bad stop bit, then a good word clears the error.
    applyStimulus(8'h2A, 1'b0);
    idleCycles(8);
    modelFrameLoss();
    checkModel("stop_err");
    applyStimulus(8'h10, 1'b1);
    applyStimulus(8'h07, 1'b1);
    idleCycles(8);
    modelByte(8'h10);
    modelByte(8'h07);
    checkModel("after_stop_err");

    // Lone low byte times out; the next byte starts a fresh word.
    applyStimulus(8'h33, 1'b1);
    idleCycles(100);
    modelByte(8'h33);
    modelFrameLoss();
    checkModel("timeout");
    applyStimulus(8'h44, 1'b1);
    applyStimulus(8'h02, 1'b1);
    idleCycles(8);
    modelByte(8'h44);
    modelByte(8'h02);
    checkModel("after_timeout");

    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    idleCycles(8);
    modelByte(8'h00);
    modelByte(8'hF0);
    checkModel("end_marker");

    // 256 random words fill the address space; the 257th lands back at 0.
    for (int w = 0; w < 256; w++) begin
      lo  = 8'($urandom_range(0, 255));
      hi  = 8'($urandom_range(0, 15));
      gap = $urandom_range(6, 12);
      applyStimulus(lo, 1'b1);
      applyStimulus(hi, 1'b1);
      idleCycles(gap);
      modelByte(lo);
      modelByte(hi);
      checkModel($sformatf("rand%0d", w));
    end
    checkOutput("wrap_addr", uart_address, 0);
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'h03, 1'b1);
    idleCycles(8);
    checkOutput("word257_write", seen_q.size() - rd_idx, 1);
    if (seen_q.size() > rd_idx) begin
      checkOutput("word257_cmd", seen_q[rd_idx].cmd, 12'h35A);
      checkOutput("word257_addr", seen_q[rd_idx].addr, 0);
    end
    modelByte(8'h5A);
    modelByte(8'h03);
    checkModel("word257");

    // Reset in the middle of a high byte's data bits.
    applyStimulus(8'h55, 1'b1);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    reset = 1'b0;
    #1;
    checkResetValues("midword_rst");
    rx = 1'b1;
    idleCycles(3);
    reset = 1'b1;
    idleCycles(10);
    modelReset();
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h01, 1'b1);
    idleCycles(8);
    modelByte(8'h11);
    modelByte(8'h01);
    checkModel("after_rst");

    // A one-cycle low pulse must not produce a byte or an error.
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    idleCycles(20);
    checkModel("glitch");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
